// File: rtl/heap_sort_sequencer.sv
// Heap-sort sequencer: collects a signed burst, heapifies it into a min-heap,
// then streams it out in ascending order with one sift level per clock.
module heap_sort_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 5,
    parameter int unsigned CW    = 16
) (
    input  logic             system1000,
    input  logic             system1000_rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [CW-1:0]    count
);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_HEAPIFY = 2'd1,
        S_EMIT    = 2'd2,
        S_SIFT    = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] heap_q [DEPTH];
    logic signed [WIDTH-1:0] heap_d [DEPTH];
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           j_q, j_d;
    logic [CW-1:0]           i_q, i_d;
    logic                    in_ready_q, out_valid_q, out_last_q, busy_q;
    logic [WIDTH-1:0]        out_data_q;

    logic [CW-1:0]           l_idx, r_idx, m_idx, last_idx;
    logic signed [WIDTH-1:0] j_val, l_val, r_val, m_val, last_val;
    logic                    sift_done;

    // One sift step at node j: find the smallest of j and its live children.
    always_comb begin
        l_idx    = (j_q << 1) + CW'(1);
        r_idx    = (j_q << 1) + CW'(2);
        last_idx = count_q - CW'(1);
        j_val    = '0;
        l_val    = '0;
        r_val    = '0;
        last_val = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (j_q == CW'(k))      j_val    = heap_q[k];
            if (l_idx == CW'(k))    l_val    = heap_q[k];
            if (r_idx == CW'(k))    r_val    = heap_q[k];
            if (last_idx == CW'(k)) last_val = heap_q[k];
        end
        m_idx = j_q;
        m_val = j_val;
        // Strict less-than: ties keep the parent, and equal children keep L.
        if ((l_idx < count_q) && (l_val < m_val)) begin
            m_idx = l_idx;
            m_val = l_val;
        end
        if ((r_idx < count_q) && (r_val < m_val)) begin
            m_idx = r_idx;
            m_val = r_val;
        end
        sift_done = (m_idx == j_q);
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        heap_d  = heap_q;
        count_d = count_q;
        j_d     = j_q;
        i_d     = i_q;
        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        if (count_q == CW'(k)) heap_d[k] = in_data;
                    end
                    count_d = count_q + CW'(1);
                    if (in_last || (count_d == CW'(DEPTH))) begin
                        state_d = S_HEAPIFY;
                        i_d     = (count_d >> 1) - CW'(1);
                        j_d     = i_d;
                    end
                end
            end
            S_HEAPIFY: begin
                if (count_q < CW'(2)) begin
                    state_d = S_EMIT;
                end else if (sift_done) begin
                    if (i_q == '0) begin
                        state_d = S_EMIT;
                    end else begin
                        i_d = i_q - CW'(1);
                        j_d = i_q - CW'(1);
                    end
                end else begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        if (j_q == CW'(k))   heap_d[k] = m_val;
                        if (m_idx == CW'(k)) heap_d[k] = j_val;
                    end
                    j_d = m_idx;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (count_q == CW'(1)) begin
                        count_d = '0;
                        state_d = S_LOAD;
                    end else begin
                        heap_d[0] = last_val;
                        count_d   = count_q - CW'(1);
                        j_d       = '0;
                        state_d   = S_SIFT;
                    end
                end
            end
            S_SIFT: begin
                if (sift_done) begin
                    state_d = S_EMIT;
                end else begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        if (j_q == CW'(k))   heap_d[k] = m_val;
                        if (m_idx == CW'(k)) heap_d[k] = j_val;
                    end
                    j_d = m_idx;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // State, heap and registered handshake outputs.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q     <= S_LOAD;
            count_q     <= '0;
            j_q         <= '0;
            i_q         <= '0;
            for (int k = 0; k < int'(DEPTH); k++) heap_q[k] <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            j_q         <= j_d;
            i_q         <= i_d;
            heap_q      <= heap_d;
            in_ready_q  <= (state_d == S_LOAD);
            out_valid_q <= (state_d == S_EMIT);
            out_last_q  <= (state_d == S_EMIT) && (count_d == CW'(1));
            busy_q      <= (state_d != S_LOAD);
            out_data_q  <= heap_d[0];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign count     = count_q;

endmodule

// File: tb/tb_heap_sort_sequencer.sv
// Directed bench for heap_sort_sequencer: sorted output order, out_last,
// backpressure, capacity limit and asynchronous reset mid-sift.
module tb_heap_sort_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_data;
    logic [15:0] count;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    heap_sort_sequencer dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .count           (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Offer one sample and wait (bounded) for it to be accepted.
    task automatic send(input logic [31:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("send_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check the word, then take it.
    task automatic pop_expect(input logic signed [31:0] exp_d, input logic exp_last);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("pop_valid", out_valid, 1);
        check("pop_data", $signed(out_data), exp_d);
        check("pop_last", out_last, exp_last);
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        int n;
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        rstn = 1'b1;
        step();

        // 1: mixed-sign burst of five, closed by in_last
        send(32'd3, 1'b0); send(-32'sd1, 1'b0); send(32'd7, 1'b0);
        send(32'd0, 1'b0); send(32'd2, 1'b1);
        check("t1_busy", busy, 1);
        check("t1_in_ready_low", in_ready, 0);
        check("t1_count", count, 5);
        pop_expect(-1, 1'b0); pop_expect(0, 1'b0); pop_expect(2, 1'b0);
        pop_expect(3, 1'b0); pop_expect(7, 1'b1);
        check("t1_in_ready_after", in_ready, 1);
        check("t1_count_after", count, 0);
        check("t1_busy_after", busy, 0);

        // 2: equal pair
        send(32'd10, 1'b0); send(32'd10, 1'b1);
        pop_expect(10, 1'b0); pop_expect(10, 1'b1);
        step(); step();
        check("t2_no_extra", out_valid, 0);
        check("t2_count", count, 0);

        // 3: single sample, output within two cycles
        send(32'd42, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("t3_latency_ok", (n <= 2), 1);
        pop_expect(42, 1'b1);

        // 4: backpressure holds the head stable
        out_ready = 1'b0;
        send(32'd5, 1'b0); send(32'd1, 1'b0); send(32'd4, 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        for (int c = 0; c < 3; c++) begin
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_data", $signed(out_data), 1);
            check("t4_hold_last", out_last, 0);
            step();
        end
        pop_expect(1, 1'b0); pop_expect(4, 1'b0); pop_expect(5, 1'b1);

        // 5: six back-to-back offers, only DEPTH accepted
        send(32'd6, 1'b0); send(32'd5, 1'b0); send(32'd4, 1'b0);
        send(32'd3, 1'b0); send(32'd2, 1'b0);
        in_valid = 1'b1; in_data = 32'd1; in_last = 1'b0;
        check("t5_ready_low", in_ready, 0);
        check("t5_count_full", count, 5);
        step();
        check("t5_ready_still_low", in_ready, 0);
        pop_expect(2, 1'b0); pop_expect(3, 1'b0); pop_expect(4, 1'b0);
        pop_expect(5, 1'b0); pop_expect(6, 1'b1);
        in_valid = 1'b0;
        check("t5_count_drained", count, 0);
        step();
        check("t5_surplus_dropped", count, 0);

        // 6: extreme values, then reset during a sift
        send(32'h7FFF_FFFF, 1'b0); send(32'h8000_0000, 1'b0); send(32'd0, 1'b1);
        pop_expect(-64'sd2147483648, 1'b0);
        check("t6_busy_in_sift", busy, 1);
        check("t6_out_valid_in_sift", out_valid, 0);
        rstn = 1'b0;
        #1;
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_count", count, 0);
        #2;
        rstn = 1'b1;
        step();
        send(32'd9, 1'b1);
        pop_expect(9, 1'b1);
        check("t6_final_count", count, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
